alu_writeback_regfile: RTL and testbench

- Consumer end of the ALU result interface (instruction word, result `c`, flags `zon`, `hi`, `lo`).
- Decodes the retiring instruction and updates a 32x32 register file and the HI/LO registers.
- Resolves beq/bne and sequences lw/sw data-memory accesses.
- Supplies the gr1/gr2 operands for the next instruction through two combinational read ports with write bypass.

---
 rtl/alu_writeback_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_alu_writeback_regfile.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_regfile.sv
// Writeback stage: retires ALU results into the GPR file and HI/LO, resolves branches,
// sequences lw/sw memory accesses, and serves bypassed operand reads for the next instruction.
module alu_writeback_regfile #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_instr,
  input  logic [31:0] wb_c,
  input  logic [2:0]  wb_zon,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic [31:0] rd_instr,
  output logic [31:0] gr1,
  output logic [31:0] gr2,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        br_valid,
  output logic        br_taken,
  output logic        ovf_trap,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_rt_q, ld_rt_d;
  logic [31:0] hi_d, lo_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        br_valid_q, br_valid_d, br_taken_q, br_taken_d;
  logic        ovf_trap_q, ovf_trap_d, illegal_q, illegal_d, mem_err_q, mem_err_d;
  logic [31:0] regs_q [32];

  logic        wen_raw, wen, is_sw;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  wb_rt, wb_rd;
  assign opcode = wb_instr[31:26];
  assign funct  = wb_instr[5:0];
  assign wb_rt  = wb_instr[20:16];
  assign wb_rd  = wb_instr[15:11];

  logic unused_ok;
  assign unused_ok = ^{wb_zon[0], rd_instr[31:26], rd_instr[15:0], wb_instr[25:21], wb_instr[10:6]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rt_d     = ld_rt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    wen_raw     = 1'b0;
    waddr       = 5'd0;
    wdata       = wb_c;
    is_sw       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    br_valid_d  = 1'b0;
    br_taken_d  = 1'b0;
    ovf_trap_d  = 1'b0;
    illegal_d   = 1'b0;
    mem_err_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (wb_valid) begin
        case (opcode)
          6'h00: begin
            case (funct)
              6'h20, 6'h22: begin
                if (wb_zon[1]) ovf_trap_d = 1'b1;
                else begin wen_raw = 1'b1; waddr = wb_rd; end
              end
              6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                wen_raw = 1'b1;
                waddr   = wb_rd;
              end
              6'h18, 6'h19, 6'h1A, 6'h1B: begin
                hi_d = wb_hi;
                lo_d = wb_lo;
              end
              default: illegal_d = 1'b1;
            endcase
          end
          6'h08: begin
            if (wb_zon[1]) ovf_trap_d = 1'b1;
            else begin wen_raw = 1'b1; waddr = wb_rt; end
          end
          6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
            wen_raw = 1'b1;
            waddr   = wb_rt;
          end
          6'h04, 6'h05: begin
            br_valid_d = 1'b1;
            br_taken_d = (opcode == 6'h04) ? wb_zon[2] : !wb_zon[2];
          end
          6'h2B: begin
            is_sw      = 1'b1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = wb_c;
          end
          6'h23: begin
            mem_req_d  = 1'b1;
            mem_addr_d = wb_c;
            ld_rt_d    = wb_rt;
            cnt_d      = 8'd0;
            state_d    = S_LOAD;
          end
          default: illegal_d = 1'b1;
        endcase
      end
    end else begin
      if (mem_rvalid) begin
        wen_raw = 1'b1;
        waddr   = ld_rt_q;
        wdata   = mem_rdata;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TIMEOUT_CNT) begin
          mem_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
    end
    wen = wen_raw && (waddr != 5'd0);
  end

  // Three read ports: rs and rt of the next instruction, and rt of a retiring sw.
  logic [4:0]  rp_addr [3];
  logic [31:0] rp_data [3];
  assign rp_addr[0] = rd_instr[25:21];
  assign rp_addr[1] = rd_instr[20:16];
  assign rp_addr[2] = wb_rt;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign rp_data[gi] = (rp_addr[gi] == 5'd0) ? 32'd0 :
                           (wen && waddr == rp_addr[gi]) ? wdata : regs_q[rp_addr[gi]];
    end
  endgenerate

  assign gr1         = rp_data[0];
  assign gr2         = rp_data[1];
  assign mem_wdata_d = is_sw ? rp_data[2] : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wen) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      ld_rt_q     <= 5'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      ovf_trap_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rt_q     <= ld_rt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      ovf_trap_q  <= ovf_trap_d;
      illegal_q   <= illegal_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign wb_ready  = (state_q == S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign br_valid  = br_valid_q;
  assign br_taken  = br_taken_q;
  assign ovf_trap  = ovf_trap_q;
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Directed bench for alu_writeback_regfile: hand-computed vectors, immediate-assertion checks.
module tb_alu_writeback_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_instr, wb_c, wb_hi, wb_lo, rd_instr;
  logic [2:0]  wb_zon;
  logic [31:0] gr1, gr2, hi_q, lo_q, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_rvalid, br_valid, br_taken, ovf_trap, illegal, mem_err;

  int tests = 0;
  int fails = 0;
  int cycles;
  int low_cnt;

  alu_writeback_regfile #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_instr(wb_instr),
    .wb_c(wb_c), .wb_zon(wb_zon), .wb_hi(wb_hi), .wb_lo(wb_lo), .rd_instr(rd_instr),
    .gr1(gr1), .gr2(gr2), .hi_q(hi_q), .lo_q(lo_q), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .br_valid(br_valid), .br_taken(br_taken), .ovf_trap(ovf_trap), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  // Reads register n through gr1 (rs) and gr2 (rt) with no write in flight.
  task automatic rd_reg(input string tag, input logic [4:0] n, input logic [31:0] exp);
    rd_instr = {6'h00, n, n, 16'h0000};
    #1;
    chk({tag, "_gr1"}, gr1, exp);
    chk({tag, "_gr2"}, gr2, exp);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] c, input logic [2:0] zon);
    wb_instr = instr;
    wb_c     = c;
    wb_zon   = zon;
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    $display("[TB] sent instr=%h c=%h zon=%b", instr, c, zon);
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_instr = 0; wb_c = 0; wb_zon = 0; wb_hi = 0; wb_lo = 0;
    rd_instr = 0; mem_rvalid = 1'b0; mem_rdata = 0;
    step(); step();
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // add rd=2, bypass visible in the write cycle
    wb_instr = rtype(5'd0, 5'd0, 5'd2, 6'h20); wb_c = 32'h1E1E1E1D; wb_zon = 3'b000;
    wb_valid = 1'b1; rd_instr = {6'h00, 5'd2, 5'd0, 16'h0}; #1;
    chk("add_bypass_gr1", gr1, 32'h1E1E1E1D);
    step(); wb_valid = 1'b0;
    $display("[TB] add rd=2 c=1E1E1E1D");
    rd_reg("add_reg2", 5'd2, 32'h1E1E1E1D);

    // addi overflow then addiu
    send(itype(6'h08, 5'd0, 5'd1), 32'h7FFFFFFE, 3'b010);
    chk("addi_ovf_pulse", 32'(ovf_trap), 32'd1);
    rd_reg("addi_ovf_reg1", 5'd1, 32'd0);
    step();
    chk("ovf_pulse_end", 32'(ovf_trap), 32'd0);
    send(itype(6'h09, 5'd0, 5'd1), 32'h7FFFFFFE, 3'b010);
    chk("addiu_no_ovf", 32'(ovf_trap), 32'd0);
    rd_reg("addiu_reg1", 5'd1, 32'h7FFFFFFE);

    // mult -> HI/LO
    wb_hi = 32'hFFFFFFFF; wb_lo = 32'hFFFFFFFF;
    send(rtype(5'd0, 5'd0, 5'd2, 6'h18), 32'h0000_0055, 3'b000);
    chk("mult_hi", hi_q, 32'hFFFFFFFF);
    chk("mult_lo", lo_q, 32'hFFFFFFFF);
    rd_reg("mult_reg2", 5'd2, 32'h1E1E1E1D);

    // branches
    send(itype(6'h04, 5'd0, 5'd0), 32'd0, 3'b100);
    chk("beq_valid", 32'(br_valid), 32'd1);
    chk("beq_taken", 32'(br_taken), 32'd1);
    send(itype(6'h05, 5'd0, 5'd0), 32'd0, 3'b100);
    chk("bne_valid", 32'(br_valid), 32'd1);
    chk("bne_taken", 32'(br_taken), 32'd0);
    step();
    chk("br_pulse_end", 32'(br_valid), 32'd0);

    // mem_rvalid in IDLE must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; step(); mem_rvalid = 1'b0;
    rd_reg("idle_rvalid_reg3", 5'd3, 32'd0);

    // lw rt=3, data after 3 cycles, second result held during wait
    send(itype(6'h23, 5'd0, 5'd3), 32'h40404060, 3'b000);
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_addr", mem_addr, 32'h40404060);
    wb_instr = rtype(5'd0, 5'd0, 5'd4, 6'h21); wb_c = 32'h44; wb_valid = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (!wb_ready) low_cnt++;
      if (k == 2) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        rd_instr = {6'h00, 5'd4, 5'd3, 16'h0}; #1;
        chk("lw_bypass_gr2", gr2, 32'hDEADBEEF);
        chk("lw_held_reg4", gr1, 32'd0);
      end
      step();
    end
    mem_rvalid = 1'b0;
    chk("lw_ready_low_cycles", 32'(low_cnt), 32'd3);
    chk("lw_ready_back", 32'(wb_ready), 32'd1);
    rd_instr = {6'h00, 5'd3, 5'd0, 16'h0}; #1;
    chk("lw_reg3", gr1, 32'hDEADBEEF);
    step(); wb_valid = 1'b0;
    $display("[TB] lw rt=3 completed, held addu accepted");
    rd_reg("held_reg4", 5'd4, 32'h44);

    // lw timeout
    send(itype(6'h23, 5'd0, 5'd5), 32'h200, 3'b000);
    cycles = 0;
    while (!mem_err && cycles < 40) begin step(); cycles++; end
    chk("timeout_cycles", 32'(cycles), 32'd15);
    chk("timeout_ready", 32'(wb_ready), 32'd1);
    rd_reg("timeout_reg5", 5'd5, 32'd0);
    step();
    chk("mem_err_pulse_end", 32'(mem_err), 32'd0);

    // reset mid-LOAD
    send(itype(6'h23, 5'd0, 5'd6), 32'h300, 3'b000);
    step(); step();
    chk("load_ready_low", 32'(wb_ready), 32'd0);
    rst = 1'b1; #1;
    chk("midrst_ready", 32'(wb_ready), 32'd1);
    rd_reg("midrst_reg1", 5'd1, 32'd0);
    step(); rst = 1'b0; step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; step(); mem_rvalid = 1'b0;
    $display("[TB] reset during load, late rvalid");
    rd_reg("late_rvalid_reg6", 5'd6, 32'd0);

    // sw rt=2
    send(rtype(5'd0, 5'd0, 5'd2, 6'h21), 32'h12345678, 3'b000);
    send(itype(6'h2B, 5'd0, 5'd2), 32'h100, 3'b000);
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_wdata", mem_wdata, 32'h12345678);
    step();
    chk("sw_req_end", 32'(mem_req), 32'd0);

    // write to $0
    wb_instr = rtype(5'd0, 5'd0, 5'd0, 6'h21); wb_c = 32'hFFFF; wb_valid = 1'b1;
    rd_instr = 32'h0; #1;
    chk("r0_no_bypass", gr1, 32'd0);
    step(); wb_valid = 1'b0;
    $display("[TB] write to r0");
    rd_reg("r0_after", 5'd0, 32'd0);

    // illegal opcode
    send(itype(6'h3F, 5'd0, 5'd7), 32'h77, 3'b000);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    rd_reg("illegal_reg7", 5'd7, 32'd0);
    step();
    chk("illegal_end", 32'(illegal), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
